// File: rtl/ysyx_23060042_isram.sv
// Instruction-memory responder: accepts one word fetch at a time and answers
// after a fixed number of wait cycles, with range/alignment error reporting.
module ysyx_23060042_isram #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1,
  localparam int unsigned IW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [IW-1:0] ld_idx,
  input  logic [31:0]   ld_data
);

  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = LO + (33'(DEPTH) << 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_err;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_addr;
  logic [32:0]   w_addr33;
  logic [32:0]   w_off;
  logic          w_err;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_word;

  // With zero latency the word is sampled on the accept edge, before r_addr holds it.
  assign w_addr   = (r_state == S_IDLE) ? req_addr : r_addr;
  assign w_addr33 = {1'b0, w_addr};
  assign w_off    = w_addr33 - LO;
  assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr33 < LO) || (w_addr33 >= HI);
  assign w_idx    = IW'(w_off >> 2);
  assign w_word   = w_err ? 32'h0 : r_mem[w_idx];

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  // Preload port is independent of reset; reads in the FSM see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'h0;
      r_rsp_data <= 32'h0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            if (LATENCY == 0) begin
              r_state    <= S_RESP;
              r_rsp_data <= w_word;
              r_rsp_err  <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= S_RESP;
            r_rsp_data <= w_word;
            r_rsp_err  <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
